// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register.
// N requesters contend; the winner's data is loaded and acknowledged.
module dff_reg_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N-1:0]       REQ,
  input  logic [N*WIDTH-1:0] DATA,
  input  logic               CLR,
  output logic [N-1:0]       GNT,
  output logic [N-1:0]       ACK,
  output logic [WIDTH-1:0]   Q,
  output logic               VALID,
  output logic               BUSY,
  output logic [7:0]         WR_COUNT
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int PX = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N-1:0] ONE = N'(1);

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] win_nx;
  logic [PW-1:0] pick;
  logic          hit;
  logic [PW:0]   idx;

  // Search ptr, ptr+1, ... wrapping at N; first set request wins.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + PX'(k);
      if (idx >= PX'(N))
        idx = idx - PX'(N);
      if (!hit && REQ[idx[PW-1:0]]) begin
        hit  = 1'b1;
        pick = idx[PW-1:0];
      end
    end
  end

  assign win_nx = (win == PW'(N - 1)) ? '0 : win + 1'b1;
  assign BUSY   = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      ptr      <= '0;
      win      <= '0;
      GNT      <= '0;
      ACK      <= '0;
      Q        <= '0;
      VALID    <= 1'b0;
      WR_COUNT <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CLR) begin
            Q     <= '0;
            VALID <= 1'b0;
          end else if (hit) begin
            GNT   <= ONE << pick;
            win   <= pick;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          GNT <= '0;
          if (REQ[win]) begin
            Q        <= DATA[int'(win)*WIDTH +: WIDTH];
            VALID    <= 1'b1;
            ACK      <= GNT;
            ptr      <= win_nx;
            WR_COUNT <= WR_COUNT + 8'd1;
            state    <= S_DONE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DONE: begin
          ACK   <= '0;
          state <= S_IDLE;
        end
        default: begin
          GNT   <= '0;
          ACK   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: directed scenarios plus random
// transactions checked against a transaction-level model.
module tb_dff_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] DATA;
  logic           CLR;
  logic [N-1:0]   GNT;
  logic [N-1:0]   ACK;
  logic [W-1:0]   Q;
  logic           VALID;
  logic           BUSY;
  logic [7:0]     WR_COUNT;

  dff_reg_arbiter #(.N(N), .WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .DATA(DATA), .CLR(CLR),
    .GNT(GNT), .ACK(ACK), .Q(Q), .VALID(VALID), .BUSY(BUSY),
    .WR_COUNT(WR_COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Transaction-level model of the architectural state
  logic [W-1:0] m_q;
  logic         m_valid;
  logic [7:0]   m_cnt;
  int           m_ptr;

  typedef logic [25:0] obs_t;

  function automatic obs_t obs();
    return {GNT, ACK, Q, VALID, BUSY, WR_COUNT};
  endfunction

  function automatic obs_t want(logic [N-1:0] g, logic [N-1:0] a,
                                logic b);
    return {g, a, m_q, m_valid, b, m_cnt};
  endfunction

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first requester at or after p, modulo N.
  function automatic int arb(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] slice(int i);
    return DATA[i*W +: W];
  endfunction

  task automatic model_reset();
    m_q = '0; m_valid = 1'b0; m_cnt = '0; m_ptr = 0;
  endtask

  task automatic model_write(int w);
    m_q = slice(w); m_valid = 1'b1;
    m_cnt = m_cnt + 8'd1; m_ptr = (w + 1) % N;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    RESET = 1'b1; CLR = 1'b0; REQ = '1;
    DATA = {$urandom, $urandom};
    tick(); tick();
    model_reset();
    e = want('0, '0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_hold: got %h want %h", obs(), e);
    end
    RESET = 1'b0;
    tick();
    e = want(4'b0001, '0, 1'b1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_first_grant: got %h want %h", obs(), e);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0; REQ = '0;
    e = want('0, '0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_in_load: got %h want %h", obs(), e);
    end
    tick();
  endtask

  task automatic test_single();
    obs_t e;
    REQ = 4'b0001; DATA = '0; DATA[7:0] = 8'hA5;
    tick();
    e = want(4'b0001, '0, 1'b1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL single_grant: got %h want %h", obs(), e);
    end
    tick();
    model_write(0);
    e = want('0, 4'b0001, 1'b1);
    checks++;
    if (obs() !== e || Q !== 8'hA5) begin
      errors++;
      $display("FAIL single_write: got %h want %h", obs(), e);
    end
    REQ = '0;
    tick();
    e = want('0, '0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL single_done: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_round_robin();
    obs_t e;
    logic [N-1:0] order;
    RESET = 1'b1; tick(); RESET = 1'b0;
    model_reset();
    DATA = 32'h44332211; REQ = 4'b1111;
    for (int i = 0; i < N; i++) begin
      tick();
      tick();
      order = oh(i);
      model_write(i);
      e = want('0, order, 1'b1);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL rr_ack%0d: got %h want %h", i, obs(), e);
      end
      REQ[i] = 1'b0;
      tick();
    end
    checks++;
    if (Q !== 8'h44 || WR_COUNT !== 8'd4) begin
      errors++;
      $display("FAIL rr_final: got q=%h cnt=%0d want q=44 cnt=4",
               Q, WR_COUNT);
    end
    // ptr back at 0: requester 1 must beat requester 3
    REQ = 4'b1010;
    tick();
    e = want(oh(arb(REQ, m_ptr)), '0, 1'b1);
    checks++;
    if (obs() !== e || GNT !== 4'b0010) begin
      errors++;
      $display("FAIL rr_ptr_zero: got %h want %h", obs(), e);
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_wrap();
    obs_t e;
    REQ = 4'b0100; DATA = {$urandom};
    tick(); tick();
    model_write(2);
    REQ = '0;
    tick();
    REQ = 4'b0101;
    tick();
    e = want(4'b0001, '0, 1'b1);
    checks++;
    if (obs() !== e || m_ptr != 3) begin
      errors++;
      $display("FAIL wrap_grant: got %h want %h", obs(), e);
    end
    tick();
    model_write(0);
    REQ = '0;
    tick();
  endtask

  task automatic test_abort();
    obs_t e;
    int w;
    REQ = 4'b0010; DATA[15:8] = 8'h5A;
    tick();
    e = want(4'b0010, '0, 1'b1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL abort_grant: got %h want %h", obs(), e);
    end
    REQ = '0;
    tick();
    e = want('0, '0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL abort_noack: got %h want %h", obs(), e);
    end
    REQ = '1;
    tick();
    w = arb(REQ, m_ptr);
    e = want(oh(w), '0, 1'b1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL abort_old_ptr: got %h want %h", obs(), e);
    end
    tick();
    model_write(w);
    REQ = '0;
    tick();
  endtask

  task automatic test_clear();
    obs_t e;
    REQ = 4'b0001; DATA = {$urandom}; DATA[7:0] = 8'hA5;
    tick(); tick();
    model_write(0);
    REQ = '0;
    tick();
    CLR = 1'b1; REQ = 4'b0100;
    tick();
    CLR = 1'b0;
    m_q = '0; m_valid = 1'b0;
    e = want('0, '0, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL clr_priority: got %h want %h", obs(), e);
    end
    tick();
    e = want(4'b0100, '0, 1'b1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL clr_then_grant: got %h want %h", obs(), e);
    end
    tick();
    model_write(2);
    e = want('0, 4'b0100, 1'b1);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL clr_then_write: got %h want %h", obs(), e);
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_random();
    obs_t e;
    int w;
    int mode;
    for (int it = 0; it < 60; it++) begin
      REQ  = N'($urandom);
      DATA = {$urandom};
      mode = $urandom_range(0, 15);
      if (mode == 0) begin
        CLR = 1'b1;
        tick();
        CLR = 1'b0; REQ = '0;
        m_q = '0; m_valid = 1'b0;
        e = want('0, '0, 1'b0);
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL rnd_clr%0d: got %h want %h", it, obs(), e);
        end
        continue;
      end
      w = arb(REQ, m_ptr);
      tick();
      e = (w < 0) ? want('0, '0, 1'b0) : want(oh(w), '0, 1'b1);
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL rnd_grant%0d: got %h want %h", it, obs(), e);
      end
      if (w < 0) continue;
      // Disturb the other inputs while the grant is held
      DATA = {$urandom};
      REQ  = N'($urandom);
      CLR  = 1'($urandom);
      if (mode == 1) begin
        RESET = 1'b1;
        tick();
        RESET = 1'b0; CLR = 1'b0; REQ = '0;
        model_reset();
        e = want('0, '0, 1'b0);
      end else if (mode < 5) begin
        REQ[w] = 1'b0;
        tick();
        CLR = 1'b0; REQ = '0;
        e = want('0, '0, 1'b0);
      end else begin
        REQ[w] = 1'b1;
        model_write(w);
        tick();
        CLR = 1'b0; REQ = '0;
        e = want('0, oh(w), 1'b1);
      end
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL rnd_load%0d: got %h want %h", it, obs(), e);
      end
      if (mode >= 5) begin
        tick();
        e = want('0, '0, 1'b0);
        checks++;
        if (obs() !== e) begin
          errors++;
          $display("FAIL rnd_done%0d: got %h want %h", it, obs(), e);
        end
      end
    end
  endtask

  initial begin
    RESET = 1'b1; REQ = '0; DATA = '0; CLR = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_abort();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
